wb_req_master: RTL and testbench
================================

WB_REQ_MASTER -- requirements
Module: wb_req_master

Interface
REQ-001 The block SHALL have parameter RETRY_MAX, default 3, the maximum number of re-issues after wb_rty_i.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, the cycles in BUS without ack/err/rty before abort; legal range 1..65535.
REQ-003 Ports SHALL be: clk_i  in  1  single clock, all logic on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 req_valid in 1, req_ready out 1, req_we in 1, req_adr in 32, req_dat in 32, req_sel in 4: command channel.
REQ-006 rsp_valid out 1, rsp_ready in 1, rsp_dat out 32, rsp_status out 2 (00 ok, 01 err, 10 retry-exhausted, 11 timeout): response channel.
REQ-007 Wishbone master side: wb_adr_o out 32, wb_dat_o out 32, wb_sel_o out 4, wb_we_o out 1, wb_cyc_o out 1, wb_stb_o out 1, wb_dat_i in 32, wb_ack_i in 1, wb_err_i in 1, wb_rty_i in 1.

Function
REQ-008 FSM states SHALL be IDLE, BUS, BACKOFF, RESP; all outputs SHALL be registered.
REQ-009 req_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with req_valid && req_ready.
REQ-010 On acceptance: adr/dat/sel/we SHALL be captured; retry count and timeout count cleared; next state BUS.
REQ-011 wb_cyc_o and wb_stb_o SHALL be 1 exactly while in BUS, first asserted the cycle after acceptance (1-cycle latency).
REQ-012 wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o SHALL hold the captured values, stable for the whole transaction including retries.
REQ-013 In BUS, response priority SHALL be ack > err > rty when sampled simultaneously.
REQ-014 BUS + ack: rsp_dat = wb_dat_i if read, 0 if write; status 00; next RESP.
REQ-015 BUS + err (no ack): rsp_dat = 0; status 01; next RESP.
REQ-016 BUS + rty only, retry count < RETRY_MAX: retry count +1, timeout count cleared, next BACKOFF.
REQ-017 BUS + rty only, retry count == RETRY_MAX: status 10, rsp_dat = 0, next RESP.
REQ-018 BUS, no ack/err/rty: timeout count +1; when it reaches TIMEOUT, status 11, rsp_dat = 0, next RESP (abort on the TIMEOUT-th idle BUS cycle).
REQ-019 BACKOFF SHALL last exactly one cycle with cyc/stb low, then BUS.
REQ-020 RESP: rsp_valid = 1, rsp_dat/rsp_status stable until rsp_valid && rsp_ready; that cycle next state IDLE, rsp_valid 0 the following cycle.
REQ-021 ack/err/rty SHALL be ignored outside BUS (no state, counter or output change).
REQ-022 Back-to-back: minimum per-transaction period with immediate ack and rsp_ready tied 1 SHALL be 3 cycles (IDLE, BUS, RESP).
REQ-023 Counters SHALL be wide enough for RETRY_MAX and TIMEOUT without wrap.

Reset
REQ-024 While rst_i = 0: state IDLE; req_ready 0 during reset, 1 the first cycle after release; rsp_valid, wb_cyc_o, wb_stb_o, wb_we_o 0; wb_adr_o, wb_dat_o, rsp_dat 0; wb_sel_o 0; rsp_status 00; counters 0.
REQ-025 Reset asserted mid-transaction SHALL drop cyc/stb asynchronously and discard the pending command with no response issued.

Verification
REQ-026 Write adr 0x1000 dat 0xDEADBEEF sel 0xF, ack 2nd BUS cycle -> cyc/stb high 2 cycles, we=1, rsp status 00, rsp_dat 0.
REQ-027 Read adr 0x20, ack with wb_dat_i 0x12345678 -> rsp_dat 0x12345678, status 00; rsp_ready held 0 for 5 cycles -> rsp stable, req_ready 0 throughout.
REQ-028 Read, rty on every BUS cycle, RETRY_MAX 3 -> 4 BUS cycles separated by 1-cycle BACKOFFs, status 10; rty twice then ack -> status 00.
REQ-029 No slave response, TIMEOUT 8 -> cyc/stb high exactly 8 cycles, status 11; ack+err+rty asserted together -> status 00.
REQ-030 rst_i low during BUS -> cyc/stb 0 immediately, no rsp_valid, next command after release completes normally.

Source files
------------

// File: rtl/wb_req_master.sv
// wb_req_master
//   Turns single commands from a valid/ready request channel into Wishbone
//   classic cycles. It retries on wb_rty_i up to RETRY_MAX times, with a
//   one-cycle backoff between attempts, and aborts a cycle when the slave is
//   silent for TIMEOUT cycles. Each command returns exactly one response on a
//   valid/ready response channel.
//
// Parameters
//   RETRY_MAX  maximum number of re-issues after wb_rty_i (default 3)
//   TIMEOUT    idle BUS cycles before abort, 1..65535 (default 255)
//
// Ports
//   clk_i, rst_i                  clock (rising edge), async active-low reset
//   req_valid/req_ready           command handshake
//   req_we/adr/dat/sel            command payload
//   rsp_valid/rsp_ready           response handshake
//   rsp_dat, rsp_status           read data (0 unless ok read), status
//                                 00 ok, 01 err, 10 retry-exhausted, 11 timeout
//   wb_*_o / wb_*_i               Wishbone master interface
module wb_req_master #(
  parameter int unsigned RETRY_MAX = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_status,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam int unsigned RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_ERR  = 2'b01;
  localparam logic [1:0] ST_RTYX = 2'b10;
  localparam logic [1:0] ST_TMO  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_BACKOFF,
    S_RESP
  } state_t;

  state_t        r_state;
  logic [RW-1:0] r_retry;
  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo_next;

  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_dat;
  logic [1:0]    r_rsp_status;
  logic [31:0]   r_adr;
  logic [31:0]   r_dat;
  logic [3:0]    r_sel;
  logic          r_we;
  logic          r_cyc;

  // r_tmo never exceeds TIMEOUT-1 while in BUS, so the increment fits in TW bits
  assign w_tmo_next = r_tmo + 1'b1;

  // All outputs are registers updated alongside the state, so each one
  // already reflects the state being entered on the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_retry      <= '0;
      r_tmo        <= '0;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_dat    <= '0;
      r_rsp_status <= ST_OK;
      r_adr        <= '0;
      r_dat        <= '0;
      r_sel        <= '0;
      r_we         <= 1'b0;
      r_cyc        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_adr       <= req_adr;
            r_dat       <= req_dat;
            r_sel       <= req_sel;
            r_we        <= req_we;
            r_retry     <= '0;
            r_tmo       <= '0;
            r_req_ready <= 1'b0;
            r_cyc       <= 1'b1;
            r_state     <= S_BUS;
          end else begin
            // also raises req_ready on the first edge after reset release
            r_req_ready <= 1'b1;
          end
        end

        S_BUS: begin
          if (wb_ack_i) begin
            r_rsp_dat    <= r_we ? '0 : wb_dat_i;
            r_rsp_status <= ST_OK;
            r_rsp_valid  <= 1'b1;
            r_cyc        <= 1'b0;
            r_state      <= S_RESP;
          end else if (wb_err_i) begin
            r_rsp_dat    <= '0;
            r_rsp_status <= ST_ERR;
            r_rsp_valid  <= 1'b1;
            r_cyc        <= 1'b0;
            r_state      <= S_RESP;
          end else if (wb_rty_i) begin
            if (r_retry < RMAX) begin
              r_retry <= r_retry + 1'b1;
              r_tmo   <= '0;
              r_cyc   <= 1'b0;
              r_state <= S_BACKOFF;
            end else begin
              r_rsp_dat    <= '0;
              r_rsp_status <= ST_RTYX;
              r_rsp_valid  <= 1'b1;
              r_cyc        <= 1'b0;
              r_state      <= S_RESP;
            end
          end else begin
            r_tmo <= w_tmo_next;
            if (w_tmo_next == TMAX) begin
              r_rsp_dat    <= '0;
              r_rsp_status <= ST_TMO;
              r_rsp_valid  <= 1'b1;
              r_cyc        <= 1'b0;
              r_state      <= S_RESP;
            end
          end
        end

        S_BACKOFF: begin
          r_cyc   <= 1'b1;
          r_state <= S_BUS;
        end

        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_cyc       <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_dat    = r_rsp_dat;
  assign rsp_status = r_rsp_status;
  assign wb_adr_o   = r_adr;
  assign wb_dat_o   = r_dat;
  assign wb_sel_o   = r_sel;
  assign wb_we_o    = r_we;
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_cyc;

endmodule

// File: tb/tb_wb_req_master.sv
module tb_wb_req_master;

  logic        clk;
  logic        rst_i;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  wb_req_master #(
    .RETRY_MAX(3),
    .TIMEOUT  (8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_dat   (req_dat),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_status(rsp_status),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_we_o   (wb_we_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .wb_rty_i  (wb_rty_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL issue_ready: req_ready=%0b exp 1", req_ready); else pass_cnt++;
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %0b exp 0", req_ready); else pass_cnt++;
    total_cnt++; if ({rsp_valid, wb_cyc_o, wb_stb_o, wb_we_o} !== 4'b0000) $display("FAIL rst_ctrl: got %b exp 0000", {rsp_valid, wb_cyc_o, wb_stb_o, wb_we_o}); else pass_cnt++;
    total_cnt++; if ({wb_adr_o, wb_dat_o, rsp_dat, wb_sel_o, rsp_status} !== '0) $display("FAIL rst_data: adr %h dat %h rsp %h sel %h st %b exp 0", wb_adr_o, wb_dat_o, rsp_dat, wb_sel_o, rsp_status); else pass_cnt++;
    rst_i = 1'b1;
    @(negedge clk);
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %0b exp 1", req_ready); else pass_cnt++;
  endtask

  task automatic test_write();
    wb_dat_i = 32'hFFFF0000;
    issue(1'b1, 32'h0000_1000, 32'hDEADBEEF, 4'hF);
    total_cnt++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111) $display("FAIL wr_bus1: cyc/stb/we %b exp 111", {wb_cyc_o, wb_stb_o, wb_we_o}); else pass_cnt++;
    total_cnt++; if ({wb_adr_o, wb_dat_o, wb_sel_o} !== {32'h1000, 32'hDEADBEEF, 4'hF}) $display("FAIL wr_payload: adr %h dat %h sel %h", wb_adr_o, wb_dat_o, wb_sel_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({wb_cyc_o, wb_stb_o} !== 2'b11) $display("FAIL wr_bus2: cyc/stb %b exp 11", {wb_cyc_o, wb_stb_o}); else pass_cnt++;
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    total_cnt++; if ({wb_cyc_o, wb_stb_o, rsp_valid, req_ready} !== 4'b0010) $display("FAIL wr_resp_ctrl: got %b exp 0010", {wb_cyc_o, wb_stb_o, rsp_valid, req_ready}); else pass_cnt++;
    total_cnt++; if ({rsp_status, rsp_dat} !== {2'b00, 32'h0}) $display("FAIL wr_resp: st %b dat %h exp 00/0", rsp_status, rsp_dat); else pass_cnt++;
    drain();
    total_cnt++; if ({rsp_valid, req_ready} !== 2'b01) $display("FAIL wr_done: valid/ready %b exp 01", {rsp_valid, req_ready}); else pass_cnt++;
  endtask

  task automatic test_read_hold();
    issue(1'b0, 32'h20, 32'h0, 4'h3);
    wb_ack_i = 1'b1; wb_dat_i = 32'h12345678;
    @(negedge clk);
    wb_ack_i = 1'b0; wb_dat_i = 32'hA5A5A5A5;
    total_cnt++; if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'b00, 32'h12345678}) $display("FAIL rd_resp: v %b st %b dat %h exp 1/00/12345678", rsp_valid, rsp_status, rsp_dat); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      // bus responses outside BUS must not disturb the held response
      wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_rty_i = 1'b1;
      @(negedge clk);
      total_cnt++; if ({rsp_valid, req_ready, wb_cyc_o, rsp_status, rsp_dat} !== {3'b100, 2'b00, 32'h12345678}) $display("FAIL rd_hold%0d: v %b rdy %b cyc %b st %b dat %h", i, rsp_valid, req_ready, wb_cyc_o, rsp_status, rsp_dat); else pass_cnt++;
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    drain();
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rd_done: rsp_valid %b exp 0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_retry_exhaust();
    int busc = 0, boc = 0, bad = 0, n = 0;
    wb_dat_i = 32'h11111111;
    issue(1'b0, 32'h40, 32'h0, 4'hF);
    wb_rty_i = 1'b1;
    while (!rsp_valid && n < 40) begin
      if (wb_cyc_o) busc++; else boc++;
      if (wb_adr_o !== 32'h40 || wb_sel_o !== 4'hF || wb_we_o !== 1'b0) bad++;
      @(negedge clk);
      n++;
    end
    wb_rty_i = 1'b0;
    total_cnt++; if (busc != 4) $display("FAIL rtyx_bus_cycles: got %0d exp 4", busc); else pass_cnt++;
    total_cnt++; if (boc != 3) $display("FAIL rtyx_backoff_cycles: got %0d exp 3", boc); else pass_cnt++;
    total_cnt++; if (bad != 0) $display("FAIL rtyx_stable: %0d unstable samples exp 0", bad); else pass_cnt++;
    total_cnt++; if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'b10, 32'h0}) $display("FAIL rtyx_resp: v %b st %b dat %h exp 1/10/0", rsp_valid, rsp_status, rsp_dat); else pass_cnt++;
    drain();
  endtask

  task automatic test_retry_then_ack();
    int busc = 0, n = 0;
    wb_dat_i = 32'hCAFEF00D;
    issue(1'b0, 32'h44, 32'h0, 4'hF);
    while (!rsp_valid && n < 40) begin
      if (wb_cyc_o) begin
        busc++;
        wb_rty_i = (busc <= 2);
        wb_ack_i = (busc > 2);
      end else begin
        wb_rty_i = 1'b0;
        wb_ack_i = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    wb_rty_i = 1'b0; wb_ack_i = 1'b0;
    total_cnt++; if (busc != 3) $display("FAIL rty2_bus_cycles: got %0d exp 3", busc); else pass_cnt++;
    total_cnt++; if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'b00, 32'hCAFEF00D}) $display("FAIL rty2_resp: v %b st %b dat %h exp 1/00/cafef00d", rsp_valid, rsp_status, rsp_dat); else pass_cnt++;
    drain();
  endtask

  task automatic test_err();
    issue(1'b0, 32'h80, 32'h0, 4'h1);
    wb_err_i = 1'b1; wb_dat_i = 32'h55;
    @(negedge clk);
    wb_err_i = 1'b0;
    total_cnt++; if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'b01, 32'h0}) $display("FAIL err_resp: v %b st %b dat %h exp 1/01/0", rsp_valid, rsp_status, rsp_dat); else pass_cnt++;
    drain();
  endtask

  task automatic test_timeout();
    int busc = 0, n = 0;
    wb_dat_i = 32'h77;
    issue(1'b0, 32'hC0, 32'h0, 4'hF);
    while (!rsp_valid && n < 40) begin
      if (wb_cyc_o && wb_stb_o) busc++;
      @(negedge clk);
      n++;
    end
    total_cnt++; if (busc != 8) $display("FAIL tmo_cycles: got %0d exp 8", busc); else pass_cnt++;
    total_cnt++; if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'b11, 32'h0}) $display("FAIL tmo_resp: v %b st %b dat %h exp 1/11/0", rsp_valid, rsp_status, rsp_dat); else pass_cnt++;
    drain();
  endtask

  task automatic test_priority();
    issue(1'b0, 32'hD0, 32'h0, 4'hF);
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_rty_i = 1'b1; wb_dat_i = 32'h0BADF00D;
    @(negedge clk);
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    total_cnt++; if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'b00, 32'h0BADF00D}) $display("FAIL prio_resp: v %b st %b dat %h exp 1/00/0badf00d", rsp_valid, rsp_status, rsp_dat); else pass_cnt++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [26:0] pat = '0;
    logic [26:0] exp_pat;
    exp_pat = 27'b100_010_001_100_010_001_100_010_001;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL b2b_start_ready: got %0b exp 1", req_ready); else pass_cnt++;
    rsp_ready = 1'b1; wb_ack_i = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h500; req_dat = 32'h1; req_sel = 4'hF;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pat = {pat[23:0], wb_cyc_o, rsp_valid, req_ready};
    end
    req_valid = 1'b0; rsp_ready = 1'b0; wb_ack_i = 1'b0;
    total_cnt++; if (pat !== exp_pat) $display("FAIL b2b_pattern: got %b exp %b", pat, exp_pat); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({wb_cyc_o, rsp_valid, req_ready} !== 3'b001) $display("FAIL b2b_idle: got %b exp 001", {wb_cyc_o, rsp_valid, req_ready}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 32'h300, 32'h9, 4'hF);
    total_cnt++; if (wb_cyc_o !== 1'b1) $display("FAIL rstm_bus: cyc %b exp 1", wb_cyc_o); else pass_cnt++;
    #2 rst_i = 1'b0;
    #1;
    total_cnt++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) $display("FAIL rstm_async: cyc/stb %b exp 00", {wb_cyc_o, wb_stb_o}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({rsp_valid, req_ready, wb_adr_o} !== {2'b00, 32'h0}) $display("FAIL rstm_hold: v %b rdy %b adr %h exp 0/0/0", rsp_valid, req_ready, wb_adr_o); else pass_cnt++;
    rst_i = 1'b1;
    @(negedge clk);
    total_cnt++; if ({req_ready, rsp_valid, wb_cyc_o} !== 3'b100) $display("FAIL rstm_release: rdy/v/cyc %b exp 100", {req_ready, rsp_valid, wb_cyc_o}); else pass_cnt++;
    issue(1'b0, 32'h304, 32'h0, 4'hF);
    wb_ack_i = 1'b1; wb_dat_i = 32'h600DCAFE;
    @(negedge clk);
    wb_ack_i = 1'b0;
    total_cnt++; if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'b00, 32'h600DCAFE}) $display("FAIL rstm_next: v %b st %b dat %h exp 1/00/600dcafe", rsp_valid, rsp_status, rsp_dat); else pass_cnt++;
    drain();
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
    rsp_ready = 1'b0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    test_reset();
    test_write();
    test_read_hold();
    test_retry_exhaust();
    test_retry_then_ack();
    test_err();
    test_timeout();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
